// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART echo path.
// Parity modes, FSM state enums and the parity rule.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Bit that makes XOR(data, bit) equal 1 for odd and 0 for even.
  // Unused data bits must be zero.
  function automatic logic parity_bit(
    input logic [7:0] data,
    input int         mode
  );
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data.
// A pop frees a slot for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array; no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop)
        level <= level + (AW+1)'(1);
      else if (do_pop && !do_push)
        level <= level - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_echo_buf.sv
// UART receive, buffer and retransmit echo path.
// Full duplex: RX and TX FSMs share only the FIFO.
module uart_echo_buf
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_d,
  input  logic                          tx_hold,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

  logic rx_s1, rx_s2, rx_prev;

  rx_state_t            rx_st, rx_st_n;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_pbit;
  logic                 rx_tick;
  logic                 rx_par_ok;
  logic                 rx_push;

  tx_state_t            tx_st, tx_st_n;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_tick;
  logic                 tx_pop;

  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Two-flop synchroniser plus history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_d;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_tick   = (rx_cnt == '0);
  assign rx_par_ok = !HAS_PAR ||
    (rx_pbit == parity_bit(8'(rx_shift), PARITY));

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) rx_st <= RX_IDLE;
    else     rx_st <= rx_st_n;
  end

  // RX next state; a high line at mid-start is a glitch.
  always_comb begin
    rx_st_n = rx_st;
    unique case (rx_st)
      RX_IDLE:
        if (rx_prev && !rx_s2) rx_st_n = RX_START;
      RX_START:
        if (rx_tick) rx_st_n = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_tick && rx_idx == IDX_LAST)
          rx_st_n = HAS_PAR ? RX_PARITY : RX_STOP;
      RX_PARITY:
        if (rx_tick) rx_st_n = RX_STOP;
      RX_STOP:
        if (rx_tick) rx_st_n = RX_IDLE;
      default:
        rx_st_n = RX_IDLE;
    endcase
  end

  // RX bit timer, shifter and end-of-frame verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_pbit    <= 1'b0;
      rx_push    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_push    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (rx_st_n != rx_st)
        rx_cnt <= (rx_st_n == RX_START) ? HALF_LAST : BIT_LAST;
      else if (rx_tick)
        rx_cnt <= BIT_LAST;
      else
        rx_cnt <= rx_cnt - CW'(1);
      if (rx_st == RX_START) rx_idx <= '0;
      if (rx_st == RX_DATA && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
        rx_idx   <= rx_idx + IW'(1);
      end
      if (rx_st == RX_PARITY && rx_tick) rx_pbit <= rx_s2;
      if (rx_st == RX_STOP && rx_tick) begin
        frame_err  <= !rx_s2;
        parity_err <= !rx_par_ok;
        rx_push    <= rx_s2 && rx_par_ok;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_shift),
    .pop   (tx_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Sticky overflow: good byte arrived with no room.
  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (rx_push && fifo_full && !tx_pop)
      overflow <= 1'b1;
  end

  assign tx_tick = (tx_cnt == '0);
  assign busy    = (tx_st != TX_IDLE) || !fifo_empty;

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) tx_st <= TX_IDLE;
    else     tx_st <= tx_st_n;
  end

  // TX next state; pop is issued on leaving IDLE.
  always_comb begin
    tx_st_n = tx_st;
    tx_pop  = 1'b0;
    unique case (tx_st)
      TX_IDLE:
        if (!fifo_empty && !tx_hold) begin
          tx_st_n = TX_LOAD;
          tx_pop  = 1'b1;
        end
      TX_LOAD:
        tx_st_n = TX_START;
      TX_START:
        if (tx_tick) tx_st_n = TX_DATA;
      TX_DATA:
        if (tx_tick && tx_idx == IDX_LAST)
          tx_st_n = HAS_PAR ? TX_PARITY : TX_STOP;
      TX_PARITY:
        if (tx_tick) tx_st_n = TX_STOP;
      TX_STOP:
        if (tx_tick) tx_st_n = TX_IDLE;
      default:
        tx_st_n = TX_IDLE;
    endcase
  end

  // TX bit timer and data shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      if (tx_st_n != tx_st || tx_tick)
        tx_cnt <= BIT_LAST;
      else
        tx_cnt <= tx_cnt - CW'(1);
      if (tx_st == TX_LOAD) begin
        tx_shift <= fifo_dout;
        tx_par   <= parity_bit(8'(fifo_dout), PARITY);
        tx_idx   <= '0;
      end
      if (tx_st == TX_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
        tx_idx   <= tx_idx + IW'(1);
      end
    end
  end

  // Line level decoded from TX state.
  always_comb begin
    tx = 1'b1;
    unique case (tx_st)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = tx_shift[0];
      TX_PARITY: tx = tx_par;
      default:   tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_echo_buf.sv
// Directed bench for uart_echo_buf with a frame scoreboard.
// Two instances: no parity and even parity.
module tb_uart_echo_buf;

  typedef struct {
    logic [10:0] frame;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx0, rx1, hold0, hold1;
  logic tx0, tx1, busy0, busy1;
  logic fe0, fe1, pe0, pe1, ov0, ov1;
  logic [2:0] lvl0, lvl1;

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int fe_cnt0 = 0, fe_cnt1 = 0;
  int pe_cnt0 = 0, pe_cnt1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fe0 === 1'b1) fe_cnt0++;
    if (fe1 === 1'b1) fe_cnt1++;
    if (pe0 === 1'b1) pe_cnt0++;
    if (pe1 === 1'b1) pe_cnt1++;
  end

  uart_echo_buf #(
    .CLK_DIV(16), .DATA_BITS(8),
    .PARITY(0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_d(rx0),
    .tx_hold(hold0), .tx(tx0), .busy(busy0),
    .frame_err(fe0), .parity_err(pe0),
    .overflow(ov0), .fifo_level(lvl0)
  );

  uart_echo_buf #(
    .CLK_DIV(16), .DATA_BITS(8),
    .PARITY(2), .FIFO_DEPTH(4)
  ) dut_p (
    .clk(clk), .rst(rst), .rx_d(rx1),
    .tx_hold(hold1), .tx(tx1), .busy(busy1),
    .frame_err(fe1), .parity_err(pe1),
    .overflow(ov1), .fifo_level(lvl1)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic void exp0(
    input logic [7:0] d, input int gap
  );
    exp_t e;
    e.frame = {2'b11, d, 1'b0};
    e.gap   = gap;
    q0.push_back(e);
  endfunction

  function automatic void exp1(input logic [7:0] d);
    exp_t e;
    e.frame = {1'b1, ^d, d, 1'b0};
    e.gap   = 0;
    q1.push_back(e);
  endfunction

  task automatic capture(
    input  int          ln,
    input  int          nb,
    output logic [10:0] fr,
    output bit          ab
  );
    fr = '1;
    ab = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        repeat (16) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
      end
      fr[i] = (ln == 0) ? tx0 : tx1;
    end
  endtask

  always begin : mon0
    logic [10:0] fr;
    bit          ab;
    int          st;
    int          prev;
    exp_t        e;
    @(negedge clk);
    if (tx0 === 1'b0 && !rst) begin
      st = cyc;
      capture(0, 10, fr, ab);
      if (!ab) begin
        if (q0.size() > 0) e = q0.pop_front();
        else begin
          e.frame = '1;
          e.gap   = 0;
        end
        check("tx0_frame", 32'(fr), 32'(e.frame));
        if (e.gap != 0)
          check("tx0_gap", st - prev, e.gap);
      end
      prev = st;
    end
  end

  always begin : mon1
    logic [10:0] fr;
    bit          ab;
    exp_t        e;
    @(negedge clk);
    if (tx1 === 1'b0 && !rst) begin
      capture(1, 11, fr, ab);
      if (!ab) begin
        if (q1.size() > 0) e = q1.pop_front();
        else begin
          e.frame = '1;
          e.gap   = 0;
        end
        check("tx1_frame", 32'(fr), 32'(e.frame));
      end
    end
  end

  task automatic send(
    input int         ln,
    input logic [7:0] d,
    input bit         par,
    input bit         pb,
    input bit         sb
  );
    logic [10:0] f;
    int n;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    n = 9;
    if (par) begin
      f[9] = pb;
      n = 10;
    end
    f[n] = sb;
    n++;
    for (int i = 0; i < n; i++) begin
      if (ln == 0) rx0 = f[i];
      else         rx1 = f[i];
      repeat (16) @(negedge clk);
    end
    if (ln == 0) rx0 = 1'b1;
    else         rx1 = 1'b1;
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0 ||
            busy0 !== 1'b0 || busy1 !== 1'b0) && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k < lim), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fe_b, pe_b, lowc;
    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    hold0 = 1'b0;
    hold1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx0, 1);
    check("rst_busy", busy0, 0);
    check("rst_fe", fe0, 0);
    check("rst_pe", pe0, 0);
    check("rst_ovf", ov0, 0);
    check("rst_lvl", lvl0, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Scenario 1: single echo of 0xA5
    hold0 = 1'b1;
    send(0, 8'hA5, 0, 0, 1);
    repeat (2) @(negedge clk);
    check("s1_lvl_one", lvl0, 1);
    check("s1_busy_q", busy0, 1);
    exp0(8'hA5, 0);
    hold0 = 1'b0;
    @(negedge clk);
    check("s1_load_idle", tx0, 1);
    @(negedge clk);
    check("s1_start", tx0, 0);
    check("s1_lvl_zero", lvl0, 0);
    repeat (80) @(negedge clk);
    check("s1_busy_mid", busy0, 1);
    wait_idle(400, "s1_done");
    check("s1_busy_end", busy0, 0);

    // Scenario 2: stop bit low
    fe_b = fe_cnt0;
    send(0, 8'h3C, 0, 0, 0);
    repeat (6) @(negedge clk);
    check("s2_fe", fe_cnt0 - fe_b, 1);
    check("s2_lvl", lvl0, 0);
    check("s2_tx", tx0, 1);

    // Scenario 3: even parity
    pe_b = pe_cnt1;
    fe_b = fe_cnt1;
    send(1, 8'h03, 1, 1, 1);
    repeat (6) @(negedge clk);
    check("s3_pe", pe_cnt1 - pe_b, 1);
    check("s3_fe", fe_cnt1 - fe_b, 0);
    check("s3_lvl", lvl1, 0);
    check("s3_tx", tx1, 1);
    exp1(8'h03);
    send(1, 8'h03, 1, 0, 1);
    wait_idle(400, "s3_done");
    check("s3_pe_good", pe_cnt1 - pe_b, 1);

    // Scenario 4: hold, fill, overflow, drain
    hold0 = 1'b1;
    send(0, 8'h11, 0, 0, 1);
    send(0, 8'h22, 0, 0, 1);
    send(0, 8'h33, 0, 0, 1);
    send(0, 8'h44, 0, 0, 1);
    repeat (4) @(negedge clk);
    check("s4_lvl_full", lvl0, 4);
    check("s4_ovf_pre", ov0, 0);
    send(0, 8'h55, 0, 0, 1);
    repeat (4) @(negedge clk);
    check("s4_lvl_keep", lvl0, 4);
    check("s4_ovf", ov0, 1);
    exp0(8'h11, 0);
    exp0(8'h22, 162);
    exp0(8'h33, 162);
    exp0(8'h44, 162);
    hold0 = 1'b0;
    wait_idle(1000, "s4_done");
    check("s4_lvl_end", lvl0, 0);
    check("s4_ovf_sticky", ov0, 1);

    // Scenario 5: short glitch on rx
    fe_b = fe_cnt0;
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (30) @(negedge clk);
    check("s5_fe", fe_cnt0 - fe_b, 0);
    check("s5_lvl", lvl0, 0);
    check("s5_busy", busy0, 0);
    exp0(8'h5A, 0);
    send(0, 8'h5A, 0, 0, 1);
    wait_idle(400, "s5_done");

    // Scenario 6: reset mid TX frame
    hold0 = 1'b1;
    send(0, 8'h66, 0, 0, 1);
    send(0, 8'h77, 0, 0, 1);
    repeat (4) @(negedge clk);
    check("s6_lvl_two", lvl0, 2);
    hold0 = 1'b0;
    repeat (40) @(negedge clk);
    check("s6_in_data", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    check("s6_tx", tx0, 1);
    check("s6_busy", busy0, 0);
    check("s6_lvl", lvl0, 0);
    check("s6_ovf", ov0, 0);
    @(negedge clk);
    rst = 1'b0;
    lowc = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx0 !== 1'b1) lowc++;
    end
    check("s6_quiet", lowc, 0);
    check("s6_lvl_end", lvl0, 0);
    check("s6_q_empty", q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
